// File: rtl/score_glyph_writer.sv
// Saturating BCD score keeper that writes each digit's 4x8 glyph word to the
// per-digit display registers whenever the score changes.
module score_glyph_writer #(
   parameter int DIGITS = 3
) (
   input  logic                clk,
   input  logic                res,
   input  logic                hit,
   input  logic                clear,
   output logic                write_en0,
   output logic [DIGITS-1:0]   right_addr,
   output logic [31:0]         pwdata,
   output logic                busy,
   output logic [4*DIGITS-1:0] score_bcd,
   output logic [1:0]          fsm_state
);

   // Write interface is a push-only strobe: right_addr/pwdata are presented in
   // SETUP and held through ACCESS; the register captures when write_en0 is high.
   // There is no ready; the sink always accepts.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          idx_q, idx_d, idx_inc;
   logic                dirty_q, dirty_d;
   logic [4*DIGITS-1:0] shadow_q, shadow_d;
   logic [31:0]         pwdata_q, pwdata_d;
   logic [4*DIGITS-1:0] score_q, score_d, score_inc, all_nines;
   logic                saturated, score_set, carry, last_digit;
   logic [3:0]          sel_digit;

   function automatic logic [31:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    glyph = 32'hF999999F;
         4'd1:    glyph = 32'h72222223;
         4'd2:    glyph = 32'hF111F88F;
         4'd3:    glyph = 32'hF888F88F;
         4'd4:    glyph = 32'h8888F999;
         4'd5:    glyph = 32'hF888F11F;
         4'd6:    glyph = 32'hF999F11F;
         4'd7:    glyph = 32'h8888888F;
         4'd8:    glyph = 32'hF999F99F;
         4'd9:    glyph = 32'hF888F99F;
         default: glyph = 32'h0;
      endcase
   endfunction

   // Decimal increment with ripple carry; nibbles never leave 0..9.
   always_comb begin
      score_inc = score_q;
      all_nines = '0;
      carry     = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         all_nines[4*i +: 4] = 4'd9;
         if (carry) begin
            if (score_q[4*i +: 4] == 4'd9) begin
               score_inc[4*i +: 4] = 4'd0;
            end else begin
               score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
      end
   end

   assign saturated = (score_q == all_nines);
   assign score_set = clear | (hit & ~saturated);

   always_comb begin
      score_d = score_q;
      if (clear) begin
         score_d = '0;
      end else if (hit && !saturated) begin
         score_d = score_inc;
      end
   end

   assign idx_inc    = idx_q + 2'd1;
   assign last_digit = (idx_q == 2'(DIGITS - 1));

   always_comb begin
      sel_digit = shadow_q[3:0];
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_inc == 2'(i)) begin
            sel_digit = shadow_q[4*i +: 4];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      dirty_d  = dirty_q | score_set;
      shadow_d = shadow_q;
      pwdata_d = pwdata_q;
      case (state_q)
         IDLE: begin
            if (dirty_q) begin
               state_d  = SETUP;
               idx_d    = 2'd0;
               // A change on this very edge re-arms the flag for the next pass.
               dirty_d  = score_set;
               shadow_d = score_q;
               pwdata_d = glyph(score_q[3:0]);
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (last_digit) begin
               state_d = IDLE;
            end else begin
               state_d  = SETUP;
               idx_d    = idx_inc;
               pwdata_d = glyph(sel_digit);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q  <= IDLE;
         idx_q    <= 2'd0;
         dirty_q  <= 1'b1;
         shadow_q <= '0;
         pwdata_q <= 32'h0;
         score_q  <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         dirty_q  <= dirty_d;
         shadow_q <= shadow_d;
         pwdata_q <= pwdata_d;
         score_q  <= score_d;
      end
   end

   always_comb begin
      right_addr = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (state_q != IDLE && idx_q == 2'(i)) begin
            right_addr[i] = 1'b1;
         end
      end
   end

   assign write_en0 = (state_q == ACCESS);
   assign busy      = (state_q != IDLE);
   assign pwdata    = pwdata_q;
   assign score_bcd = score_q;
   assign fsm_state = state_q;

endmodule

// File: tb/tb_score_glyph_writer.sv
// Directed bench for score_glyph_writer: expected glyph writes are queued as
// stimulus is issued and a monitor checks every write strobe against them.
module tb_score_glyph_writer;

   localparam int DIGITS    = 3;
   localparam int W         = DIGITS + 32;
   localparam int MAX_SCORE = 999;

   logic                clk = 1'b0;
   logic                res = 1'b0;
   logic                hit = 1'b0;
   logic                clear = 1'b0;
   logic                write_en0;
   logic [DIGITS-1:0]   right_addr;
   logic [31:0]         pwdata;
   logic                busy;
   logic [4*DIGITS-1:0] score_bcd;
   logic [1:0]          fsm_state;

   logic [W-1:0] exp_q[$];
   int           n_checks = 0;
   int           n_pass   = 0;
   int           model_score = 0;

   logic [31:0] glyph_tab [10] = '{
      32'hF999999F, 32'h72222223, 32'hF111F88F, 32'hF888F88F, 32'h8888F999,
      32'hF888F11F, 32'hF999F11F, 32'h8888888F, 32'hF999F99F, 32'hF888F99F
   };

   score_glyph_writer #(.DIGITS(DIGITS)) dut (
      .clk        (clk),
      .res        (res),
      .hit        (hit),
      .clear      (clear),
      .write_en0  (write_en0),
      .right_addr (right_addr),
      .pwdata     (pwdata),
      .busy       (busy),
      .score_bcd  (score_bcd),
      .fsm_state  (fsm_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
      logic [4*DIGITS-1:0] r;
      int t;
      t = v;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   task automatic push_digit(input int i, input int score);
      logic [4*DIGITS-1:0] b;
      logic [DIGITS-1:0]   a;
      logic [3:0]          d;
      b = to_bcd(score);
      a = DIGITS'(1) << i;
      d = b[4*i +: 4];
      exp_q.push_back({a, glyph_tab[d]});
   endtask

   task automatic push_pass(input int score);
      for (int i = 0; i < DIGITS; i++) push_digit(i, score);
   endtask

   // driver: one-cycle pulse of hit/clear, model update, score check
   task automatic pulse(input logic h, input logic c, input bit push, output bit changed);
      int old;
      old = model_score;
      @(negedge clk);
      hit = h;
      clear = c;
      if (c) model_score = 0;
      else if (h && model_score < MAX_SCORE) model_score++;
      changed = c || (model_score != old);
      if (changed && push) push_pass(model_score);
      @(negedge clk);
      hit = 1'b0;
      clear = 1'b0;
      chk("score", score_bcd, to_bcd(model_score));
   endtask

   task automatic count_busy(input int n0);
      int n;
      n = n0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (busy) n++;
         else break;
      end
      chk("pass_len", n, 2 * DIGITS);
   endtask

   task automatic wait_pass();
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      chk("pass_start", seen, 1);
      if (seen) count_busy(1);
   endtask

   task automatic no_pass();
      bit seen;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      chk("no_pass", seen, 0);
   endtask

   // monitor / scoreboard
   logic              prev_busy = 1'b0;
   logic              prev_we = 1'b0;
   logic [DIGITS-1:0] prev_addr = '0;
   logic [31:0]       prev_data = '0;

   always @(negedge clk) begin
      if (res && write_en0) begin
         chk("setup_before_strobe", {prev_busy, prev_we, prev_addr, prev_data},
             {1'b1, 1'b0, right_addr, pwdata});
         chk("write_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            chk("write_addr_data", {right_addr, pwdata}, e);
         end
      end
      prev_busy = busy;
      prev_we   = write_en0;
      prev_addr = right_addr;
      prev_data = pwdata;
   end

   // main sequence
   initial begin
      bit ch;
      bit found;
      int n;

      @(negedge clk);
      chk("rst_we", write_en0, 0);
      chk("rst_addr", right_addr, 0);
      chk("rst_pwdata", pwdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_score", score_bcd, 0);
      push_pass(0);
      res = 1'b1;
      wait_pass();

      // single hit
      pulse(1'b1, 1'b0, 1'b1, ch);
      wait_pass();
      chk("single_bcd", score_bcd, 12'h001);

      // carry
      pulse(1'b0, 1'b1, 1'b1, ch);
      wait_pass();
      repeat (10) begin
         pulse(1'b1, 1'b0, 1'b1, ch);
         wait_pass();
      end
      chk("carry_bcd", score_bcd, 12'h010);

      // saturation
      pulse(1'b0, 1'b1, 1'b1, ch);
      wait_pass();
      for (int k = 0; k < 1005; k++) begin
         pulse(1'b1, 1'b0, 1'b1, ch);
         if (ch) wait_pass();
         else no_pass();
      end
      chk("sat_bcd", score_bcd, 12'h999);

      // hit during ACCESS(1) of the pass for 005
      pulse(1'b0, 1'b1, 1'b1, ch);
      wait_pass();
      repeat (4) begin
         pulse(1'b1, 1'b0, 1'b1, ch);
         wait_pass();
      end
      pulse(1'b1, 1'b0, 1'b1, ch);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (write_en0 && right_addr == 3'b010) found = 1'b1;
      end
      chk("found_access1", found, 1);
      hit = 1'b1;
      model_score = 6;
      push_pass(6);
      @(negedge clk);
      hit = 1'b0;
      n = 0;
      while (busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("gap_idle", busy, 0);
      @(negedge clk);
      chk("gap_restart", busy, 1);
      count_busy(1);
      chk("midpass_bcd", score_bcd, 12'h006);

      // hit together with clear
      pulse(1'b1, 1'b1, 1'b1, ch);
      wait_pass();
      chk("clr_hit_bcd", score_bcd, 12'h000);

      // reset during SETUP(1)
      pulse(1'b1, 1'b0, 1'b0, ch);
      push_digit(0, 1);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (busy && !write_en0 && right_addr == 3'b010) found = 1'b1;
      end
      chk("found_setup1", found, 1);
      #2;
      res = 1'b0;
      #1;
      chk("mid_rst_we", write_en0, 0);
      chk("mid_rst_addr", right_addr, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_pwdata", pwdata, 0);
      chk("mid_rst_score", score_bcd, 0);
      model_score = 0;
      push_pass(0);
      @(negedge clk);
      res = 1'b1;
      wait_pass();

      repeat (5) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/score_glyph_writer.md
# score_glyph_writer

Score keeper and bus writer for the score display. Counts hit pulses into a saturating BCD score and converts each digit to a 4x8 glyph bitmap. On every score change, it writes one 32-bit glyph word per digit over the peripheral write interface (`write_en0` / `right_addr` / `pwdata`) into the per-digit display registers. The pixel renderer reads those registers back. This block is the producing end of that register path, so no software is needed in the scoring loop.

## Interface
- `DIGITS`, default 3. Number of BCD digits and display sinks. Legal values are 1 to 4.
- `clk`: input, 1 bit. System clock; all state changes on its rising edge.
- `res`: input, 1 bit. Asynchronous, active-low reset.
- `hit`: input, 1 bit. Add-one request, sampled every clock. Held high means one increment per cycle.
- `clear`: input, 1 bit. Sets the score to zero. Sampled every clock and overrides `hit` in the same cycle.
- `write_en0`: output, 1 bit. Write strobe to the display registers. High only in ACCESS cycles.
- `right_addr`: output, `DIGITS` bits. One-hot select of the target digit register. Bit 0 is the ones digit.
- `pwdata`: output, 32 bits. Glyph word for the selected digit.
- `busy`: output, 1 bit. High whenever the write state machine is not in IDLE.
- `score_bcd`: output, 4*`DIGITS` bits. Live BCD score. Nibble 0 is the ones digit.

## Operation
- **Score counter**
  - On `clear`, all nibbles become 0.
  - Otherwise, on `hit`, the BCD value increments with decimal carry.
  - At all-nines (999 for `DIGITS`=3) the score saturates and further hits have no effect.
  - No nibble ever holds a value above 9.
- **Dirty flag**
  - Set by any `clear`, by any `hit` that changes the score, and by reset.
  - Cleared on the IDLE to SETUP transition.
  - A `hit` in the same cycle as that transition sets the flag again, so it is never lost.
- **Snapshot**
  - On entering SETUP for digit 0, `score_bcd` is copied into a shadow register.
  - All digits of one pass come from that shadow, so a pass never mixes two score values.
- **Glyph encoding**
  - Bit index = row*4 + col. Row 0 is the top row; col 0 is the leftmost column.
  - Digit glyphs:
    - 0 = F999999F
    - 1 = 72222223
    - 2 = F111F88F
    - 3 = F888F88F
    - 4 = 8888F999
    - 5 = F888F11F
    - 6 = F999F11F
    - 7 = 8888888F
    - 8 = F999F99F
    - 9 = F888F99F
- **State machine**: states IDLE, SETUP(i), ACCESS(i), for i = 0 to `DIGITS`-1.
  - IDLE: go to SETUP(0) if dirty is set, otherwise stay.
  - SETUP(i): drive `pwdata` = glyph(shadow digit i) and `right_addr` = 1<<i, with `write_en0` = 0. Next state is ACCESS(i).
  - ACCESS(i): hold the same `pwdata` and `right_addr` with `write_en0` = 1. Next state is SETUP(i+1), or IDLE after the last digit.
  - IDLE outputs: `write_en0` = 0 and `right_addr` = 0. `pwdata` holds its last value.
- **Mid-pass score change**: the current pass completes unchanged. Dirty stays set, so a fresh pass starts from IDLE one cycle after the current pass ends.
- **Reset**: asserting `res` at any time, including mid-pass, forces IDLE immediately with all outputs at their reset values. No partial write is completed.

## Timing
- **Reset values**: `write_en0` = 0, `right_addr` = 0, `pwdata` = 0, `busy` = 0, `score_bcd` = 0, dirty = 1.
- **After reset release**: the first rising edge enters SETUP(0), so "0…0" is written without any stimulus.
- **Score latency**: `hit` or `clear` sampled at edge E updates `score_bcd` immediately after E.
- **Write latency**, for an idle machine with dirty set at E:
  - SETUP(0) occupies the cycle after E+1.
  - ACCESS(i) occupies the cycle after edge E+2+2i.
- **Pass length**: 2*`DIGITS` cycles. `busy` is high for exactly those cycles.
- **Gap**: at least one IDLE cycle separates consecutive passes.
- **Write strobe**: `write_en0` is a single-cycle pulse per digit. `pwdata` and `right_addr` are stable from SETUP through ACCESS.

## Test plan
- **Reset, no stimulus**: release `res` with all inputs idle.
  - Three SETUP/ACCESS pairs occur, each with `pwdata` = F999999F.
  - `right_addr` goes 001, 010, 100.
  - `busy` is high for 6 cycles, then low.
- **Single hit**: one `hit` pulse after idle.
  - `score_bcd` = 001.
  - The pass writes 72222223 to addr 001, then F999999F to 010 and 100.
- **Carry**: 10 hits.
  - `score_bcd` = 010.
  - Final pass writes F999999F to 001, 72222223 to 010 and F999999F to 100.
- **Saturation**: 1005 hits.
  - `score_bcd` stays at 999.
  - Last pass writes F888F99F to all three addresses.
  - Once saturated, further hits start no pass.
- **Hit mid-pass**: `hit` during ACCESS(1) of a pass for score 005.
  - The pass completes with 5's glyph (F888F11F) on addr 001.
  - After one IDLE cycle, a new pass writes 6's glyph (F999F11F).
  - `hit` together with `clear` gives a score of 000.
- **Reset mid-pass**: `res` low during SETUP(1).
  - `write_en0`, `right_addr` and `busy` drop to 0 at once.
  - After release, a full 000 pass runs.
